rvga_mem_arbiter: RTL and testbench
===================================

# rvga_mem_arbiter

Shares the core's single memory port between the instruction-fetch requester and the data (load/store) requester. It runs one transaction at a time, with data priority and a bounded-starvation guarantee for fetch. It sits between the fetch/memory pipeline stages and the external memory interface, and routes each response back to the requester that issued it.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8
- STARVE_LIMIT, 4, maximum consecutive contested data grants before fetch is forced to win; must be ≥ 1
- clk_i  in  1  clock; all logic on rising edge
- reset_n_i  in  1  synchronous, active-low reset
- if_req_v_i  in  1  fetch request valid
- if_addr_i  in  ADDR_W  fetch address
- if_req_ready_o  out  1  fetch request accepted this cycle
- if_resp_v_o  out  1  fetch response valid (one-cycle pulse)
- if_resp_data_o  out  DATA_W  fetch response data
- dm_req_v_i  in  1  data request valid
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_wmask_i  in  DATA_W/8  store byte mask
- dm_req_ready_o  out  1  data request accepted this cycle
- dm_resp_v_o  out  1  data response valid (one-cycle pulse; also the store acknowledge)
- dm_resp_data_o  out  DATA_W  load data
- mem_req_v_o  out  1  memory request valid
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_wmask_o  out  DATA_W/8  memory byte mask
- mem_req_ready_i  in  1  memory accepted the request
- mem_resp_v_i  in  1  memory response valid (issued for both loads and stores)
- mem_resp_data_i  in  DATA_W  memory response data

## Operation
- **FSM states:** IDLE, REQ, WAIT.
- **IDLE:**
  - If any request is valid, pick a winner and assert its req_ready_o combinationally in the same cycle.
  - Capture the winner's we/addr/wdata/wmask and the owner bit (0 = fetch, 1 = data).
  - Go to REQ. Exactly one req_ready_o is high in any cycle.
- **Arbitration:**
  - Only one requester valid: that requester wins.
  - Both valid: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - Fetch captures are stored with we = 0 and mask = all ones.
- **starve_cnt:**
  - Width clog2(STARVE_LIMIT+1).
  - Increments (saturating) on a data grant while if_req_v_i is high.
  - Clears on any fetch grant.
  - Otherwise holds.
- **REQ:**
  - mem_req_v_o = 1; mem_* outputs driven from the capture registers.
  - On mem_req_ready_i, go to WAIT.
  - Captured fields stay stable while waiting.
- **WAIT:**
  - mem_req_v_o = 0.
  - On mem_resp_v_i: pulse the owner's resp_v_o in the same cycle; resp_data_o = mem_resp_data_i passed through combinationally; go to IDLE.
- **Outside WAIT:** mem_resp_v_i is ignored.
- **Non-owner outputs:** the non-owner's resp_v_o is always 0. resp_data_o outputs are don't-care when their resp_v_o is 0.
- **Requester obligations:** a requester holds valid and its fields stable until req_ready_o. Dropping valid before that is legal and withdraws the request.

## Timing
- **Reset (reset_n_i = 0 at a rising edge):**
  - State goes to IDLE; starve_cnt, owner and the capture registers clear to 0.
  - All outputs are 0 on the cycle after the reset edge.
  - Reset mid-transaction drops the outstanding transaction. The memory side is reset in the same cycle by system requirement.
- **Latency:**
  - Accept at cycle T.
  - mem_req_v_o high from T+1.
  - With mem_req_ready_i at T+1, earliest response is T+2.
  - resp_v_o rises in the same cycle as mem_resp_v_i.
  - Next accept is no earlier than the cycle after the response.
  - Minimum 3 cycles per transaction; throughput at most 1 transaction per 3 cycles.
- **Back-pressure:** mem_req_ready_i low extends REQ indefinitely. mem_resp_v_i low extends WAIT indefinitely. No timeout.
- **Simultaneous events:**
  - A new request arriving in the response cycle is not accepted until IDLE (next cycle).
  - Both requesters valid in IDLE: exactly one accepted. The loser's ready stays 0 until a later IDLE cycle.
- **Fairness bound:** with both requesters continuously valid, fetch is granted at least once every STARVE_LIMIT+1 grants.

## Test plan
- **Single fetch:** if_req_v_i = 1, addr 0x100; memory ready immediately, responds 1 cycle later with 0xDEADBEEF. Required:
  - if_req_ready_o at T.
  - mem_req_v_o with addr 0x100, we = 0, mask 0xF at T+1.
  - if_resp_v_o with 0xDEADBEEF at T+2; dm_resp_v_o stays 0.
- **Store:** dm_req_v_i = 1, we = 1, addr 0x200, wdata 0x12345678, mask 0x3; mem_req_ready_i held low 3 cycles. Required:
  - mem_* outputs stable across all stall cycles.
  - dm_resp_v_o pulses once, on the response cycle.
- **Contention with STARVE_LIMIT = 4:** both requesters continuously valid. Required grant order: D, D, D, D, F, D, D, D, D, F.
- **Fetch alone:** fetch requests only, 10 back-to-back. Required:
  - starve_cnt stays 0.
  - Grants at accept cycles spaced exactly 3 apart with zero-latency memory.
- **Reset mid-transaction:** reset_n_i = 0 during WAIT, then a stray mem_resp_v_i after reset. Required:
  - All outputs 0 after the reset edge.
  - No resp_v_o pulse from the stray response.
  - The next request is accepted normally.
- **Spurious response:** mem_resp_v_i = 1 while in IDLE or REQ. Required: no resp_v_o pulse and no state change.

Source files
------------

// File: rtl/rvga_mem_arbiter.sv
// rvga_mem_arbiter: shares one memory port between the instruction-fetch and
// data requesters. It runs one transaction at a time. Data wins contested
// grants until fetch has been passed over STARVE_LIMIT times in a row; after
// that, fetch is forced to win. Each response is routed back to the requester
// that owns the outstanding transaction.
module rvga_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                if_req_v_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_req_ready_o,
  output logic                if_resp_v_o,
  output logic [DATA_W-1:0]   if_resp_data_o,
  input  logic                dm_req_v_i,
  input  logic                dm_we_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  input  logic [DATA_W/8-1:0] dm_wmask_i,
  output logic                dm_req_ready_o,
  output logic                dm_resp_v_o,
  output logic [DATA_W-1:0]   dm_resp_data_o,
  output logic                mem_req_v_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_req_ready_i,
  input  logic                mem_resp_v_i,
  input  logic [DATA_W-1:0]   mem_resp_data_i
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              grant_if, grant_dm;
  logic              resp_hit;

  // Pick at most one winner while idle; fetch wins only when uncontested or starved.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state_q == ST_IDLE) begin
      if (if_req_v_i && (!dm_req_v_i || (starve_cnt_q == CNT_MAX))) begin
        grant_if = 1'b1;
      end else if (dm_req_v_i) begin
        grant_dm = 1'b1;
      end
    end
  end

  // Next state, capture of the winning request and starvation bookkeeping.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_if) begin
          owner_d      = 1'b0;
          we_d         = 1'b0;
          addr_d       = if_addr_i;
          wdata_d      = '0;
          wmask_d      = '1;
          starve_cnt_d = '0;
          state_d      = ST_REQ;
        end else if (grant_dm) begin
          owner_d = 1'b1;
          we_d    = dm_we_i;
          addr_d  = dm_addr_i;
          wdata_d = dm_wdata_i;
          wmask_d = dm_wmask_i;
          // Only a grant that actually passes over a waiting fetch counts.
          if (if_req_v_i && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_resp_v_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and capture registers; reset drops any outstanding transaction.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

  // Output decode: memory side from captures, responses steered to the owner.
  always_comb begin
    resp_hit       = (state_q == ST_WAIT) && mem_resp_v_i;
    if_req_ready_o = grant_if;
    dm_req_ready_o = grant_dm;
    mem_req_v_o    = (state_q == ST_REQ);
    mem_we_o       = we_q;
    mem_addr_o     = addr_q;
    mem_wdata_o    = wdata_q;
    mem_wmask_o    = wmask_q;
    if_resp_v_o    = resp_hit && !owner_q;
    dm_resp_v_o    = resp_hit && owner_q;
    // Data is gated so idle response buses read as zero.
    if_resp_data_o = (resp_hit && !owner_q) ? mem_resp_data_i : '0;
    dm_resp_data_o = (resp_hit && owner_q) ? mem_resp_data_i : '0;
  end

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Bench for rvga_mem_arbiter: directed scenarios, a transaction-level model
// compared every cycle, and literal expectations for the key scenarios.
module tb_rvga_mem_arbiter;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int MASK_W       = DATA_W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n_i;
  logic              if_req_v_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_req_ready_o, if_resp_v_o;
  logic [DATA_W-1:0] if_resp_data_o;
  logic              dm_req_v_i, dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [MASK_W-1:0] dm_wmask_i;
  logic              dm_req_ready_o, dm_resp_v_o;
  logic [DATA_W-1:0] dm_resp_data_o;
  logic              mem_req_v_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [MASK_W-1:0] mem_wmask_o;
  logic              mem_req_ready_i, mem_resp_v_i;
  logic [DATA_W-1:0] mem_resp_data_i;

  rvga_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .if_req_v_i(if_req_v_i), .if_addr_i(if_addr_i), .if_req_ready_o(if_req_ready_o),
    .if_resp_v_o(if_resp_v_o), .if_resp_data_o(if_resp_data_o),
    .dm_req_v_i(dm_req_v_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_wmask_i(dm_wmask_i), .dm_req_ready_o(dm_req_ready_o),
    .dm_resp_v_o(dm_resp_v_o), .dm_resp_data_o(dm_resp_data_o),
    .mem_req_v_o(mem_req_v_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_resp_v_i(mem_resp_v_i),
    .mem_resp_data_i(mem_resp_data_i)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  int                stall_cfg = 0;
  int                lat_cfg   = 0;
  logic [DATA_W-1:0] rdata_cfg = '0;
  bit                spur_resp = 1'b0;
  logic [DATA_W-1:0] spur_data = '0;
  int                stall_ctr = 0;
  int                wait_ctr  = 0;
  bit                resp_pending = 1'b0;

  initial forever begin
    @(posedge clk);
    #2;
    mem_req_ready_i = 1'b0;
    mem_resp_v_i    = spur_resp;
    mem_resp_data_i = spur_data;
    if (!reset_n_i) begin
      resp_pending = 1'b0;
      stall_ctr    = 0;
    end else if (resp_pending) begin
      if (wait_ctr == 0) begin
        mem_resp_v_i    = 1'b1;
        mem_resp_data_i = rdata_cfg;
        resp_pending    = 1'b0;
      end else begin
        wait_ctr--;
      end
    end else if (mem_req_v_o) begin
      if (stall_ctr < stall_cfg) begin
        stall_ctr++;
      end else begin
        mem_req_ready_i = 1'b1;
        stall_ctr       = 0;
        resp_pending    = 1'b1;
        wait_ctr        = lat_cfg;
      end
    end
  end

  // ---------------- transaction-level model ----------------
  bit                m_busy   = 1'b0;   // a transaction is owned by someone
  bit                m_issued = 1'b0;   // memory has taken the request
  bit                m_owner  = 1'b0;   // 1 = data
  bit                m_we     = 1'b0;
  logic [ADDR_W-1:0] m_addr   = '0;
  logic [DATA_W-1:0] m_wdata  = '0;
  logic [MASK_W-1:0] m_wmask  = '0;
  int                m_streak = 0;      // consecutive data grants that passed over fetch
  bit                grant_f[$];        // 1 = fetch grant, 0 = data grant
  int                grant_cyc[$];
  bit                mg_i, mg_d, cg_i, cg_d;

  function automatic void model_grants(output bit gi, output bit gd);
    gi = 1'b0;
    gd = 1'b0;
    if (!m_busy) begin
      if (if_req_v_i && (!dm_req_v_i || (m_streak >= STARVE_LIMIT))) gi = 1'b1;
      else if (dm_req_v_i) gd = 1'b1;
    end
  endfunction

  initial forever begin
    @(posedge clk);
    model_grants(mg_i, mg_d);
    if (!reset_n_i) begin
      m_busy = 1'b0; m_issued = 1'b0; m_owner = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_wmask = '0; m_streak = 0;
    end else if (!m_busy) begin
      if (mg_i) begin
        m_busy = 1'b1; m_issued = 1'b0; m_owner = 1'b0; m_we = 1'b0;
        m_addr = if_addr_i; m_wdata = '0; m_wmask = '1; m_streak = 0;
        grant_f.push_back(1'b1); grant_cyc.push_back(cyc);
      end else if (mg_d) begin
        m_busy = 1'b1; m_issued = 1'b0; m_owner = 1'b1; m_we = dm_we_i;
        m_addr = dm_addr_i; m_wdata = dm_wdata_i; m_wmask = dm_wmask_i;
        if (if_req_v_i && m_streak < STARVE_LIMIT) m_streak = m_streak + 1;
        grant_f.push_back(1'b0); grant_cyc.push_back(cyc);
      end
    end else if (!m_issued) begin
      if (mem_req_ready_i) m_issued = 1'b1;
    end else if (mem_resp_v_i) begin
      m_busy = 1'b0;
    end
    cyc++;
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      model_grants(cg_i, cg_d);
      chk("if_req_ready", 64'(if_req_ready_o), 64'(cg_i));
      chk("dm_req_ready", 64'(dm_req_ready_o), 64'(cg_d));
      chk("mem_req_v", 64'(mem_req_v_o), 64'(m_busy && !m_issued));
      chk("mem_we", 64'(mem_we_o), 64'(m_we));
      chk("mem_addr", 64'(mem_addr_o), 64'(m_addr));
      chk("mem_wmask", 64'(mem_wmask_o), 64'(m_wmask));
      if (m_owner) chk("mem_wdata", 64'(mem_wdata_o), 64'(m_wdata));
      chk("if_resp_v", 64'(if_resp_v_o), 64'(m_busy && m_issued && mem_resp_v_i && !m_owner));
      chk("dm_resp_v", 64'(dm_resp_v_o), 64'(m_busy && m_issued && mem_resp_v_i && m_owner));
      if (m_busy && m_issued && mem_resp_v_i && !m_owner)
        chk("if_resp_data", 64'(if_resp_data_o), 64'(mem_resp_data_i));
      if (m_busy && m_issued && mem_resp_v_i && m_owner)
        chk("dm_resp_data", 64'(dm_resp_data_o), 64'(mem_resp_data_i));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (m_busy && n < 50) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(m_busy), 64'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_ready"}, 64'(if_req_ready_o), 64'(0));
    chk({tag, "_dm_ready"}, 64'(dm_req_ready_o), 64'(0));
    chk({tag, "_if_resp_v"}, 64'(if_resp_v_o), 64'(0));
    chk({tag, "_dm_resp_v"}, 64'(dm_resp_v_o), 64'(0));
    chk({tag, "_if_rdata"}, 64'(if_resp_data_o), 64'(0));
    chk({tag, "_dm_rdata"}, 64'(dm_resp_data_o), 64'(0));
    chk({tag, "_mem_v"}, 64'(mem_req_v_o), 64'(0));
    chk({tag, "_mem_we"}, 64'(mem_we_o), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr_o), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata_o), 64'(0));
    chk({tag, "_mem_wmask"}, 64'(mem_wmask_o), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    start, wait_n, pulses, pulse_at;
    string exp_order;
    reset_n_i = 1'b0; if_req_v_i = 1'b0; if_addr_i = '0;
    dm_req_v_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0; dm_wmask_i = '0;
    tick(); tick();
    reset_n_i = 1'b1;
    chk_en    = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");

    // Single fetch, zero-latency memory.
    tick();
    if_req_v_i = 1'b1; if_addr_i = 32'h100; rdata_cfg = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_if_ready", 64'(if_req_ready_o), 64'(1));
    chk("t1_dm_ready", 64'(dm_req_ready_o), 64'(0));
    tick();
    if_req_v_i = 1'b0;
    @(negedge clk);
    chk("t1_mem_v", 64'(mem_req_v_o), 64'(1));
    chk("t1_mem_addr", 64'(mem_addr_o), 64'h100);
    chk("t1_mem_we", 64'(mem_we_o), 64'(0));
    chk("t1_mem_mask", 64'(mem_wmask_o), 64'hF);
    tick();
    @(negedge clk);
    chk("t1_if_resp_v", 64'(if_resp_v_o), 64'(1));
    chk("t1_if_rdata", 64'(if_resp_data_o), 64'hDEADBEEF);
    chk("t1_dm_resp_v", 64'(dm_resp_v_o), 64'(0));
    tick();

    // Store with three stall cycles on the request handshake.
    stall_cfg = 3; rdata_cfg = '0;
    dm_req_v_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h200;
    dm_wdata_i = 32'h12345678; dm_wmask_i = 4'h3;
    @(negedge clk);
    chk("t2_dm_ready", 64'(dm_req_ready_o), 64'(1));
    tick();
    dm_req_v_i = 1'b0; dm_we_i = 1'b0;
    pulses = 0; pulse_at = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i <= 4) begin
        chk("t2_stall_v", 64'(mem_req_v_o), 64'(1));
        chk("t2_stall_we", 64'(mem_we_o), 64'(1));
        chk("t2_stall_addr", 64'(mem_addr_o), 64'h200);
        chk("t2_stall_wdata", 64'(mem_wdata_o), 64'h12345678);
        chk("t2_stall_mask", 64'(mem_wmask_o), 64'h3);
      end
      if (dm_resp_v_o) begin
        pulses++;
        pulse_at = i;
      end
      if (i < 6) tick();
    end
    chk("t2_pulse_count", 64'(pulses), 64'(1));
    chk("t2_pulse_cycle", 64'(pulse_at), 64'(5));
    stall_cfg = 0;
    tick();

    // Contention: both requesters continuously valid.
    start = grant_f.size();
    if_req_v_i = 1'b1; if_addr_i = 32'h400;
    dm_req_v_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h500;
    wait_n = 0;
    while (grant_f.size() < start + 10 && wait_n < 100) begin
      tick();
      wait_n++;
    end
    if_req_v_i = 1'b0; dm_req_v_i = 1'b0;
    chk("t3_timeout", 64'(wait_n < 100), 64'(1));
    exp_order = "DDDDFDDDDF";
    for (int i = 0; i < 10; i++) begin
      if (start + i < grant_f.size())
        chk("t3_grant_order", 64'(grant_f[start+i]), 64'(exp_order[i] == "F"));
    end
    drain();

    // Fetch only: ten back-to-back grants.
    start = grant_f.size();
    if_req_v_i = 1'b1; if_addr_i = 32'h600;
    wait_n = 0;
    while (grant_f.size() < start + 10 && wait_n < 100) begin
      tick();
      wait_n++;
      chk("t4_starve_cnt", 64'(dut.starve_cnt_q), 64'(0));
    end
    if_req_v_i = 1'b0;
    chk("t4_timeout", 64'(wait_n < 100), 64'(1));
    for (int i = 1; i < 10; i++) begin
      if (start + i < grant_cyc.size())
        chk("t4_spacing", 64'(grant_cyc[start+i] - grant_cyc[start+i-1]), 64'(3));
    end
    drain();

    // Reset during WAIT, then a stray response.
    lat_cfg = 5;
    dm_req_v_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300;
    @(negedge clk);
    chk("t5_dm_ready", 64'(dm_req_ready_o), 64'(1));
    tick();
    dm_req_v_i = 1'b0;
    tick();
    @(negedge clk);
    chk("t5_in_wait", 64'(mem_req_v_o), 64'(0));
    tick();
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    @(negedge clk);
    chk_all_zero("t5_after_reset");
    tick();
    spur_resp = 1'b1; spur_data = 32'hBADBAD00;
    @(negedge clk);
    chk("t5_stray_if", 64'(if_resp_v_o), 64'(0));
    chk("t5_stray_dm", 64'(dm_resp_v_o), 64'(0));
    tick();
    spur_resp = 1'b0; lat_cfg = 0;
    if_req_v_i = 1'b1; if_addr_i = 32'h700; rdata_cfg = 32'hCAFEF00D;
    @(negedge clk);
    chk("t5_next_ready", 64'(if_req_ready_o), 64'(1));
    tick();
    if_req_v_i = 1'b0;
    tick();
    @(negedge clk);
    chk("t5_next_resp_v", 64'(if_resp_v_o), 64'(1));
    chk("t5_next_rdata", 64'(if_resp_data_o), 64'hCAFEF00D);
    tick();

    // Spurious responses in IDLE and in REQ.
    spur_resp = 1'b1; spur_data = 32'h55AA55AA;
    @(negedge clk);
    chk("t6_idle_if", 64'(if_resp_v_o), 64'(0));
    chk("t6_idle_dm", 64'(dm_resp_v_o), 64'(0));
    tick();
    spur_resp = 1'b0; stall_cfg = 2; rdata_cfg = 32'h0BADF00D;
    dm_req_v_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h800;
    dm_wdata_i = 32'hA5A5A5A5; dm_wmask_i = 4'hC;
    @(negedge clk);
    chk("t6_dm_ready", 64'(dm_req_ready_o), 64'(1));
    tick();
    dm_req_v_i = 1'b0; dm_we_i = 1'b0;
    spur_resp = 1'b1;
    @(negedge clk);
    chk("t6_req_dm_resp", 64'(dm_resp_v_o), 64'(0));
    chk("t6_req_still_v", 64'(mem_req_v_o), 64'(1));
    tick();
    spur_resp = 1'b0;
    @(negedge clk);
    chk("t6_req_hold_v", 64'(mem_req_v_o), 64'(1));
    chk("t6_req_hold_addr", 64'(mem_addr_o), 64'h800);
    drain();
    stall_cfg = 0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
